old_control_logic: RTL and testbench
====================================

OLD_CONTROL_LOGIC -- requirements
Module: old_control_logic

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port order SHALL be: clk, reset, opcode, ALUsrc, ALUop, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite.
REQ-003 clk  input  1  rising-edge clock for all output registers.
REQ-004 reset  input  1  asynchronous, active-high; clears all outputs.
REQ-005 opcode  input  6  MIPS instruction bits [31:26].
REQ-006 ALUsrc  output  1  1 = ALU operand B is the sign-extended immediate; 0 = register rt.
REQ-007 ALUop  output  2  00 = add (load/store/addi); 01 = subtract (branch compare); 10 = R-type, use funct; 11 = never driven.
REQ-008 RegDst  output  1  1 = write register rd; 0 = write register rt.
REQ-009 MemWrite  output  1  data memory write enable.
REQ-010 MemRead  output  1  data memory read enable.
REQ-011 Beq  output  1  branch-if-equal instruction.
REQ-012 Bne  output  1  branch-if-not-equal instruction.
REQ-013 Jump  output  1  unconditional jump instruction.
REQ-014 MemToReg  output  1  1 = register write data comes from memory; 0 = from ALU.
REQ-015 RegWrite  output  1  register file write enable.

Function
REQ-016 All 11 output bits SHALL be registered and SHALL update only on the rising edge of clk.
- Latency is exactly 1 cycle from opcode to outputs.
- No combinational path from opcode to any output.
REQ-017 Decoded values, listed as ALUsrc, ALUop, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite:
- R-type (000000): 0, 10, 1, 0, 0, 0, 0, 0, 0, 1.
- lw (100011): 1, 00, 0, 0, 1, 0, 0, 0, 1, 1.
- sw (101011): 1, 00, 0, 1, 0, 0, 0, 0, 0, 0.
- beq (000100): 0, 01, 0, 0, 0, 1, 0, 0, 0, 0.
- bne (000101): 0, 01, 0, 0, 0, 0, 1, 0, 0, 0.
- j (000010): 0, 00, 0, 0, 0, 0, 0, 1, 0, 0.
- addi (001000): 1, 00, 0, 0, 0, 0, 0, 0, 0, 1.
REQ-018 Any other opcode (for example 111011 or 100001) SHALL decode to all outputs 0 (ALUop = 00), a safe NOP.
REQ-019 Fields that are don't-care for an instruction SHALL be driven 0; outputs SHALL never be X or Z after reset.
REQ-020 Mutual exclusion SHALL hold on every cycle:
- At most one of Beq, Bne, Jump is high.
- MemRead and MemWrite are never both high.
- MemWrite = 1 implies RegWrite = 0.
REQ-021 An opcode that is unknown (X) SHALL be decoded as an unrecognised opcode, giving all outputs 0.

Reset
REQ-022 While reset = 1, all outputs SHALL be 0 immediately, without waiting for a clock edge, regardless of opcode.
REQ-023 After reset deasserts, the first rising edge of clk SHALL register the decode of the current opcode.
REQ-024 Reset asserted mid-stream SHALL discard the pending decode; no partial update of the outputs is allowed.

Verification
REQ-025 Reset: assert reset with opcode = 100011 -> all outputs 0 before any clock edge; release reset, one edge -> lw vector 1, 00, 0, 0, 1, 0, 0, 0, 1, 1.
REQ-026 Opcode sequence 000000, 100011, 101011, 000100, applied on consecutive edges -> each REQ-017 vector appears exactly one cycle after its opcode.
REQ-027 Unrecognised opcodes 111011 and 100001 -> all outputs 0 on the next edge.
REQ-028 bne (000101) then j (000010) -> Bne = 1 with ALUop = 01, then Jump = 1 with all other outputs 0.
REQ-029 Change opcode between edges (no clock) -> outputs hold; reset pulse mid-cycle -> outputs 0 at once.
REQ-030 Sweep all 64 opcodes with random clock gaps -> REQ-020 invariants hold on every cycle, and every opcode outside REQ-017 yields all outputs 0.

Source files
------------

// File: rtl/old_control_logic.sv
//------------------------------------------------------------------------------
// old_control_logic : registered MIPS main-control decoder (opcode -> datapath controls)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module old_control_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       ALUsrc,
  output logic [1:0] ALUop,
  output logic       RegDst,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       Beq,
  output logic       Bne,
  output logic       Jump,
  output logic       MemToReg,
  output logic       RegWrite
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Control bundle bit order:
  // [10] ALUsrc [9:8] ALUop [7] RegDst [6] MemWrite [5] MemRead
  // [4] Beq [3] Bne [2] Jump [1] MemToReg [0] RegWrite
  logic [10:0] ctrl_d;
  logic [10:0] ctrl_q;

  always_comb begin
    ctrl_d = 11'b0;
    // An X opcode matches no item and falls to the all-zero NOP default.
    case (opcode)
      OP_RTYPE: ctrl_d = 11'b0_10_1_0_0_0_0_0_0_1;
      OP_LW:    ctrl_d = 11'b1_00_0_0_1_0_0_0_1_1;
      OP_SW:    ctrl_d = 11'b1_00_0_1_0_0_0_0_0_0;
      OP_BEQ:   ctrl_d = 11'b0_01_0_0_0_1_0_0_0_0;
      OP_BNE:   ctrl_d = 11'b0_01_0_0_0_0_1_0_0_0;
      OP_J:     ctrl_d = 11'b0_00_0_0_0_0_0_1_0_0;
      OP_ADDI:  ctrl_d = 11'b1_00_0_0_0_0_0_0_0_1;
      default:  ctrl_d = 11'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= 11'b0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ALUsrc   = ctrl_q[10];
  assign ALUop    = ctrl_q[9:8];
  assign RegDst   = ctrl_q[7];
  assign MemWrite = ctrl_q[6];
  assign MemRead  = ctrl_q[5];
  assign Beq      = ctrl_q[4];
  assign Bne      = ctrl_q[3];
  assign Jump     = ctrl_q[2];
  assign MemToReg = ctrl_q[1];
  assign RegWrite = ctrl_q[0];

endmodule

`default_nettype wire

// File: tb/tb_old_control_logic.sv
//------------------------------------------------------------------------------
// tb_old_control_logic : directed self-checking bench for old_control_logic
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_old_control_logic;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       ALUsrc;
  logic [1:0] ALUop;
  logic       RegDst;
  logic       MemWrite;
  logic       MemRead;
  logic       Beq;
  logic       Bne;
  logic       Jump;
  logic       MemToReg;
  logic       RegWrite;

  int vectors;
  int miscompares;

  logic [10:0] obs;
  assign obs = {ALUsrc, ALUop, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite};

  old_control_logic dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .ALUsrc   (ALUsrc),
    .ALUop    (ALUop),
    .RegDst   (RegDst),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Beq      (Beq),
    .Bne      (Bne),
    .Jump     (Jump),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite)
  );

  // Expected control vector from the instruction table; anything else is NOP.
  function automatic logic [10:0] exp_ctrl(input logic [5:0] op);
    logic [10:0] r;
    r = 11'b0;
    case (op)
      6'b000000: r = 11'b0_10_1_0_0_0_0_0_0_1;
      6'b100011: r = 11'b1_00_0_0_1_0_0_0_1_1;
      6'b101011: r = 11'b1_00_0_1_0_0_0_0_0_0;
      6'b000100: r = 11'b0_01_0_0_0_1_0_0_0_0;
      6'b000101: r = 11'b0_01_0_0_0_0_1_0_0_0;
      6'b000010: r = 11'b0_00_0_0_0_0_0_1_0_0;
      6'b001000: r = 11'b1_00_0_0_0_0_0_0_0_1;
      default:   r = 11'b0;
    endcase
    return r;
  endfunction

  // One clock pulse; returns at the falling edge, away from the active edge.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    opcode = 6'b100011;
    #2;
    vectors++;
    if (obs !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_async obs=%b exp=%b", obs, 11'b0);
    end
    #3 reset = 1'b0;
    #2;
    vectors++;
    if (obs !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_release_noclk obs=%b exp=%b", obs, 11'b0);
    end
    tick();
    vectors++;
    if (obs !== 11'b1_00_0_0_1_0_0_0_1_1) begin
      miscompares++;
      $display("FAIL reset_first_lw obs=%b exp=%b", obs, 11'b1_00_0_0_1_0_0_0_1_1);
    end
  endtask

  task automatic test_sequence();
    logic [5:0]  ops [4];
    logic [10:0] exps[4];
    ops[0] = 6'b000000; exps[0] = 11'b0_10_1_0_0_0_0_0_0_1;
    ops[1] = 6'b100011; exps[1] = 11'b1_00_0_0_1_0_0_0_1_1;
    ops[2] = 6'b101011; exps[2] = 11'b1_00_0_1_0_0_0_0_0_0;
    ops[3] = 6'b000100; exps[3] = 11'b0_01_0_0_0_1_0_0_0_0;
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i];
      tick();
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL seq[%0d] op=%b obs=%b exp=%b", i, ops[i], obs, exps[i]);
      end
    end
    opcode = 6'b001000;
    tick();
    vectors++;
    if (obs !== 11'b1_00_0_0_0_0_0_0_0_1) begin
      miscompares++;
      $display("FAIL seq_addi obs=%b exp=%b", obs, 11'b1_00_0_0_0_0_0_0_0_1);
    end
  endtask

  task automatic test_unrecognised();
    logic [5:0] ops [2];
    ops[0] = 6'b111011;
    ops[1] = 6'b100001;
    for (int i = 0; i < 2; i++) begin
      opcode = 6'b000000;
      tick();
      opcode = ops[i];
      tick();
      vectors++;
      if (obs !== 11'b0) begin
        miscompares++;
        $display("FAIL unrecognised op=%b obs=%b exp=%b", ops[i], obs, 11'b0);
      end
    end
  endtask

  task automatic test_bne_j();
    opcode = 6'b000101;
    tick();
    vectors++;
    if (obs !== 11'b0_01_0_0_0_0_1_0_0_0) begin
      miscompares++;
      $display("FAIL bne obs=%b exp=%b", obs, 11'b0_01_0_0_0_0_1_0_0_0);
    end
    opcode = 6'b000010;
    tick();
    vectors++;
    if (obs !== 11'b0_00_0_0_0_0_0_1_0_0) begin
      miscompares++;
      $display("FAIL jump obs=%b exp=%b", obs, 11'b0_00_0_0_0_0_0_1_0_0);
    end
  endtask

  task automatic test_hold_and_async_reset();
    opcode = 6'b100011;
    tick();
    opcode = 6'b101011;
    #3;
    opcode = 6'b000000;
    #3;
    vectors++;
    if (obs !== 11'b1_00_0_0_1_0_0_0_1_1) begin
      miscompares++;
      $display("FAIL hold_noclk obs=%b exp=%b", obs, 11'b1_00_0_0_1_0_0_0_1_1);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 11'b0) begin
      miscompares++;
      $display("FAIL midcycle_reset obs=%b exp=%b", obs, 11'b0);
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (obs !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_discard obs=%b exp=%b", obs, 11'b0);
    end
    tick();
    vectors++;
    if (obs !== 11'b0_10_1_0_0_0_0_0_0_1) begin
      miscompares++;
      $display("FAIL post_reset_rtype obs=%b exp=%b", obs, 11'b0_10_1_0_0_0_0_0_0_1);
    end
  endtask

  task automatic test_unknown_opcode();
    opcode = 6'b100011;
    tick();
    opcode = 6'bxxxxxx;
    tick();
    vectors++;
    if (obs !== exp_ctrl(opcode)) begin
      miscompares++;
      $display("FAIL unknown_x obs=%b exp=%b", obs, exp_ctrl(opcode));
    end
  endtask

  task automatic test_sweep();
    logic [10:0] e;
    for (int op = 0; op < 64; op++) begin
      opcode = 6'(op);
      #($urandom_range(0, 7));
      opcode = 6'(op);
      tick();
      e = exp_ctrl(6'(op));
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL sweep op=%b obs=%b exp=%b", 6'(op), obs, e);
      end
      vectors++;
      if ((32'(Beq) + 32'(Bne) + 32'(Jump)) > 1 || (MemRead && MemWrite) ||
          (MemWrite && RegWrite) || ALUop === 2'b11) begin
        miscompares++;
        $display("FAIL invariant op=%b obs=%b exp=%b", 6'(op), obs, e);
      end
    end
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b0;
    opcode      = 6'b0;
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sequence();
    test_unrecognised();
    test_bne_j();
    test_hold_and_async_reset();
    test_unknown_opcode();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
